alu_mc_unit: RTL and testbench

//  Parametrised multi-cycle ALU. It is the WIDTH-bit successor of the 1-bit Ainvert/Binvert/Operation slice.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 78 +++++++
 rtl/alu_mc_unit.sv | 181 ++++++++++++++++++
 tb/tb_alu_mc_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the multi-cycle ALU: op-code encodings in the
//   {Ainvert, Binvert, Operation[1:0]} format, FSM state encoding, and the
//   op legality check used by the decoder.
// ---------------------------------------------------------------------------
package alu_pkg;

  // {Ainvert, Binvert, Operation[1:0]}
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // MUL is only legal when the iterative multiplier is built in.
  function automatic logic is_legal(input logic [3:0] op_code, input logic mul_en);
    logic legal;
    case (op_code)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: legal = 1'b1;
      OP_MUL:                                        legal = mul_en;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
//   Unsigned shift-add multiplier, one multiplier bit per clock.
//   start loads the operands and a WIDTH-count; WIDTH iteration edges later
//   the product is complete. done is high in the cycle before the final
//   iteration edge, while prod_lo/prod_hi_nz already show the value that
//   edge completes, so the caller can register the product on that edge.
// Ports
//   clk, rst_n   clock, async active-low reset
//   start        load a/b and begin (ignored bits of a/b afterwards)
//   a, b         multiplicand, multiplier
//   done         final iteration in progress this cycle
//   prod_lo      low WIDTH bits of the product (valid while done)
//   prod_hi_nz   high WIDTH bits of the product are non-zero (valid while done)
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_sum_s;

  // Next-state for one shift-add step; the counter doubles as the busy flag.
  always_comb begin
    acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      acc_d    = {(2*WIDTH){1'b0}};
      mplier_d = b;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != {CW{1'b0}}) begin
      acc_d    = acc_sum_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end else begin
      cnt_d    = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done       = (cnt_q == CW'(1));
  assign prod_lo    = acc_sum_s[WIDTH-1:0];
  assign prod_hi_nz = |acc_sum_s[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mc_unit.sv
// ---------------------------------------------------------------------------
// alu_mc_unit
//   WIDTH-bit multi-cycle ALU with valid/ready on both sides. AND/OR/ADD/
//   SUB/SLT/NOR complete in one edge; MUL iterates for WIDTH+1 edges. The
//   result and flags are registered and held until consumed.
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid, in_ready    input handshake (op, a, b sampled on transfer)
//   op                    {Ainvert, Binvert, Operation[1:0]}
//   a, b                  operands
//   out_valid, out_ready  output handshake
//   result                registered result
//   zero, carry, ovf, err registered flags
// ---------------------------------------------------------------------------
module alu_mc_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic             ready_en_q, ready_en_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             in_ready_s, accept_s, legal_s, mul_start_s;
  logic [WIDTH-1:0] a_p_s, b_p_s;
  logic [WIDTH:0]   sum_s;
  logic             add_ovf_s;
  logic [WIDTH-1:0] sc_result_s;
  logic             sc_carry_s, sc_ovf_s;
  logic             mul_done_s, mul_hi_nz_s;
  logic [WIDTH-1:0] mul_lo_s;

  // ready_en_q keeps in_ready low while reset is asserted (the handshake
  // term alone would read 1 in IDLE with out_valid cleared).
  assign in_ready_s  = ready_en_q & (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign accept_s    = in_valid & in_ready_s;
  assign legal_s     = is_legal(op, MUL_EN);
  assign mul_start_s = accept_s & legal_s & (op == OP_MUL);

  // Shared invert/add path; Binvert doubles as carry-in so SUB is a+~b+1.
  assign a_p_s     = op[3] ? ~a : a;
  assign b_p_s     = op[2] ? ~b : b;
  assign sum_s     = {1'b0, a_p_s} + {1'b0, b_p_s} + {{WIDTH{1'b0}}, op[2]};
  assign add_ovf_s = (a_p_s[MSB] == b_p_s[MSB]) & (sum_s[MSB] != a_p_s[MSB]);

  // Single-cycle result selection; SLT corrects the sign with overflow.
  always_comb begin
    sc_result_s = {WIDTH{1'b0}};
    sc_carry_s  = 1'b0;
    sc_ovf_s    = 1'b0;
    case (op)
      OP_AND, OP_NOR: sc_result_s = a_p_s & b_p_s;
      OP_OR:          sc_result_s = a_p_s | b_p_s;
      OP_ADD, OP_SUB: begin
        sc_result_s = sum_s[WIDTH-1:0];
        sc_carry_s  = sum_s[WIDTH];
        sc_ovf_s    = add_ovf_s;
      end
      OP_SLT:         sc_result_s = {{(WIDTH-1){1'b0}}, sum_s[MSB] ^ add_ovf_s};
      default:        sc_result_s = {WIDTH{1'b0}};
    endcase
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start_s),
    .a          (a),
    .b          (b),
    .done       (mul_done_s),
    .prod_lo    (mul_lo_s),
    .prod_hi_nz (mul_hi_nz_s)
  );

  // FSM, handshake and output-register next-state.
  always_comb begin
    state_d     = state_q;
    ready_en_d  = 1'b1;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    if (state_q == ST_MUL) begin
      if (mul_done_s) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b1;
        result_d    = mul_lo_s;
        zero_d      = (mul_lo_s == {WIDTH{1'b0}});
        carry_d     = 1'b0;
        ovf_d       = mul_hi_nz_s;
        err_d       = 1'b0;
      end else begin
        state_d     = ST_MUL;
      end
    end else if (accept_s) begin
      if (!legal_s) begin
        out_valid_d = 1'b1;
        result_d    = {WIDTH{1'b0}};
        zero_d      = 1'b1;
        carry_d     = 1'b0;
        ovf_d       = 1'b0;
        err_d       = 1'b1;
      end else if (op == OP_MUL) begin
        // Accept implies any pending result drains on this edge.
        state_d     = ST_MUL;
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        result_d    = sc_result_s;
        zero_d      = (sc_result_s == {WIDTH{1'b0}});
        carry_d     = sc_carry_s;
        ovf_d       = sc_ovf_s;
        err_d       = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_mc_unit
//   Scoreboard bench: the driver pushes the expected response for every
//   accepted transaction; an independent monitor pops and compares whenever
//   the DUT hands out a result. A second instance has the multiplier removed.
// ---------------------------------------------------------------------------
module tb_alu_mc_unit;

  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_MUL = 4'b1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, carry, ovf, err;

  logic         n_in_valid = 1'b0;
  logic         n_in_ready;
  logic [3:0]   n_op = 4'd0;
  logic [W-1:0] n_a = '0;
  logic [W-1:0] n_b = '0;
  logic         n_out_valid;
  logic         n_out_ready = 1'b1;
  logic [W-1:0] n_result;
  logic         n_zero, n_carry, n_ovf, n_err;

  alu_mc_unit #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .ovf(ovf), .err(err)
  );

  alu_mc_unit #(.WIDTH(W), .MUL_EN(1'b0)) u_dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .op(n_op), .a(n_a), .b(n_b), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_result), .zero(n_zero), .carry(n_carry), .ovf(n_ovf), .err(n_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         err;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  int   last_pop_cyc = -1;
  int   last_acc_cyc = -1;
  bit   rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic definitions of each operation.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [W:0]  s;
    logic [63:0] p;
    longint      sx, sy, sr;
    e     = '0;
    e.lat = 1;
    sx = $signed({{32{x[W-1]}}, x});
    sy = $signed({{32{y[W-1]}}, y});
    case (o)
      C_AND: e.res = x & y;
      C_OR:  e.res = x | y;
      C_NOR: e.res = ~(x | y);
      C_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.carry = s[W];
        sr = sx + sy;
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      C_SUB: begin
        e.res = x - y;
        e.carry = (x >= y);
        sr = sx - sy;
        e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      C_SLT: e.res = (sx < sy) ? 32'd1 : 32'd0;
      C_MUL: begin
        p = {32'd0, x} * {32'd0, y};
        e.res = p[31:0];
        e.ovf = (p[63:32] != 32'd0);
        e.lat = W + 1;
      end
      default: begin
        e.res = '0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Present one transaction and hold it until accepted (bounded).
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   waitc;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    waitc = 0;
    forever begin
      #4;
      if (in_ready) begin
        e = model(o, x, y);
        e.acc_cyc = cyc;
        last_acc_cyc = cyc;
        sb_q.push_back(e);
        break;
      end
      waitc++;
      if (waitc > 200) begin
        chk("accept_timeout", 64'(waitc), 64'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  // Drop in_valid and scribble on the operand bus.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      op = 4'($urandom);
      a = $urandom;
      b = $urandom;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    int k;
    k = $urandom_range(0, 19);
    case (k)
      17, 18: return C_MUL;
      19: return 4'($urandom);
      default: begin
        case (k % 6)
          0: return C_AND;
          1: return C_OR;
          2: return C_ADD;
          3: return C_SUB;
          4: return C_SLT;
          default: return C_NOR;
        endcase
      end
    endcase
  endfunction

  // Monitor: drives out_ready, checks latency, hold stability and values.
  initial begin : monitor
    logic         prev_valid;
    logic         prev_taken;
    logic         snap_ok;
    logic [W+4:0] snap;
    exp_t         e;
    prev_valid = 1'b0;
    prev_taken = 1'b0;
    snap_ok    = 1'b0;
    snap       = '0;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else if (rand_bp) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      #4;
      if (snap_ok) chk("hold_stable", 64'({out_valid, result, zero, carry, ovf, err}), 64'(snap));
      snap_ok = 1'b0;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_valid || prev_taken)
            chk("latency", 64'(cyc), 64'(sb_q[0].acc_cyc + sb_q[0].lat));
          if (out_ready) begin
            e = sb_q.pop_front();
            chk("result", 64'(result), 64'(e.res));
            chk("flags", 64'({zero, carry, ovf, err}), 64'({e.zero, e.carry, e.ovf, e.err}));
            last_pop_cyc = cyc;
          end else begin
            snap_ok = 1'b1;
            snap = {1'b1, result, zero, carry, ovf, err};
          end
        end
      end
      prev_valid = out_valid;
      prev_taken = out_valid & out_ready;
    end
  end

  initial begin : main
    logic [3:0]   d_op [6] = '{C_ADD, C_SUB, C_SLT, C_SLT, C_NOR, C_OR};
    logic [W-1:0] d_a  [6] = '{32'h7FFF_FFFF, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0F0F_0000, 32'h0};
    logic [W-1:0] d_b  [6] = '{32'h1, 32'h5, 32'h1, 32'h7FFF_FFFF, 32'h00FF_00FF, 32'h0};

    repeat (3) @(negedge clk);
    #2;
    chk("reset_state", 64'({in_ready, out_valid, result, zero, carry, ovf, err}), 64'd0);
    chk("reset_state_nomul", 64'({n_in_ready, n_out_valid, n_result, n_err}), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed single-cycle corners.
    for (int i = 0; i < 6; i++) issue(d_op[i], d_a[i], d_b[i]);
    idle(1);
    wait_drain();

    // Directed MUL, in_ready must stay low while iterating.
    issue(C_MUL, 32'h0001_2345, 32'h0000_0010);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = C_ADD; a = $urandom; b = $urandom;
      #4;
      chk("mul_busy_ready", 64'(in_ready), 64'd0);
    end
    issue(C_MUL, 32'hFFFF_FFFF, 32'h0000_0002);
    idle(1);
    wait_drain();

    // Back-pressure: AND held for 5 cycles, then accept-and-drain.
    hold_cnt = 6;
    issue(C_AND, 32'h0000_00F0, 32'h0000_003C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = C_OR; a = 32'h0000_000F; b = 32'h0000_0030;
      #4;
      chk("bp_no_accept", 64'(in_ready), 64'd0);
    end
    issue(C_OR, 32'h0000_000F, 32'h0000_0030);
    idle(1);
    chk("bp_back_to_back", 64'(last_acc_cyc), 64'(last_pop_cyc));
    wait_drain();

    // Reset in the middle of a MUL; no result may come out afterwards.
    issue(C_ADD, 32'h1, 32'h1);
    issue(C_MUL, 32'h0000_0123, 32'h0000_0456);
    idle(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({in_ready, out_valid, result, zero, carry, ovf, err}), 64'd0);
    sb_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);
    issue(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0);
    idle(40);
    wait_drain();

    // Instance without the multiplier: MUL decodes as illegal.
    @(negedge clk);
    n_in_valid = 1'b1; n_op = C_MUL; n_a = 32'h0000_0003; n_b = 32'h0000_0005;
    #4;
    chk("nomul_ready", 64'(n_in_ready), 64'd1);
    @(negedge clk);
    n_in_valid = 1'b1; n_op = C_ADD; n_a = 32'h0000_0003; n_b = 32'h0000_0004;
    #4;
    chk("nomul_err", 64'({n_out_valid, n_result, n_zero, n_carry, n_ovf, n_err}),
        64'({1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    n_in_valid = 1'b0;
    #4;
    chk("nomul_add", 64'({n_out_valid, n_result, n_zero, n_carry, n_ovf, n_err}),
        64'({1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0}));

    // Randomised traffic with random back-pressure.
    rand_bp = 1'b1;
    for (int t = 0; t < 250; t++) begin
      issue(rand_op(), rand_opnd(), rand_opnd());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    wait_drain();
    rand_bp = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
